// File: rtl/ps2_pkg.sv
// PS/2 shared definitions: host transmitter FSM encoding and command bytes.
// Used by ps2_host_tx and by the receiver side.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_DATA      = 3'd3,
    ST_PARITY    = 3'd4,
    ST_STOP      = 3'd5,
    ST_WAIT_IDLE = 3'd6
  } ps2_state_e;

  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] PS2_ACK          = 8'hFA;

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 clock/data pad synchronizer with a registered falling-edge strobe
// on the clock line; the strobe is aligned with o_clk going low.
module ps2_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clk_raw,
  input  logic i_data_raw,
  output logic o_clk,
  output logic o_data,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_fall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_fall      <= 1'b0;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_clk_raw};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_data_raw};
      r_fall      <= r_clk_sync[SYNC_STAGES-1] & ~r_clk_sync[SYNC_STAGES-2];
    end
  end

  assign o_clk  = r_clk_sync[SYNC_STAGES-1];
  assign o_data = r_data_sync[SYNC_STAGES-1];
  assign o_fall = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter (inhibit, start, 8 data, odd parity, stop, ACK).
// Define PS2_TX_TIMEOUT_EN to enable the device-clock watchdog.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_PRE  = IW'(INHIBIT_CYCLES - 2);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);
`ifdef PS2_TX_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  ps2_state_e    r_state;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [2:0]    r_bitcnt;
  logic [IW-1:0] r_cnt;
  logic [WW-1:0] r_wdog;
  logic          r_clk_oe;
  logic          r_data_oe;
  logic          r_ready;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  logic w_clk_s;
  logic w_data_s;
  logic w_fall;
  logic w_wd_act;
  logic w_timeout;

  ps2_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .i_clk_raw (ps2_clk_in),
    .i_data_raw(ps2_data_in),
    .o_clk     (w_clk_s),
    .o_data    (w_data_s),
    .o_fall    (w_fall)
  );

  assign w_wd_act  = (r_state != ST_IDLE) && (r_state != ST_INHIBIT);
  assign w_timeout = WD_EN && w_wd_act && !w_fall && (r_wdog == WD_LAST);

  // Held clear through INHIBIT so it starts from zero on entry to REQ.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wdog <= '0;
    end else if (r_state == ST_INHIBIT || w_fall) begin
      r_wdog <= '0;
    end else if (r_wdog != WD_LAST) begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_bitcnt  <= '0;
      r_cnt     <= '0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_timeout) begin
        r_state   <= ST_IDLE;
        r_clk_oe  <= 1'b0;
        r_data_oe <= 1'b0;
        r_err     <= 1'b1;
        r_ready   <= 1'b1;
        r_busy    <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (tx_valid && r_ready) begin
              r_shift  <= tx_data;
              r_parity <= ~^tx_data;
              r_cnt    <= '0;
              r_clk_oe <= 1'b1;
              r_ready  <= 1'b0;
              r_busy   <= 1'b1;
              r_state  <= ST_INHIBIT;
            end
          end
          ST_INHIBIT: begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == INH_PRE) r_data_oe <= 1'b1;
            if (r_cnt == INH_LAST) begin
              r_clk_oe <= 1'b0;
              r_state  <= ST_REQ;
            end
          end
          ST_REQ: begin
            if (w_fall) begin
              r_data_oe <= ~r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bitcnt  <= '0;
              r_state   <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (w_fall) begin
              if (r_bitcnt == 3'd7) begin
                r_data_oe <= ~r_parity;
                r_state   <= ST_PARITY;
              end else begin
                r_data_oe <= ~r_shift[0];
                r_shift   <= r_shift >> 1;
                r_bitcnt  <= r_bitcnt + 1'b1;
              end
            end
          end
          ST_PARITY: begin
            if (w_fall) begin
              r_data_oe <= 1'b0;
              r_state   <= ST_STOP;
            end
          end
          ST_STOP: begin
            if (w_fall) begin
              if (!w_data_s) begin
                r_state <= ST_WAIT_IDLE;
              end else begin
                r_err   <= 1'b1;
                r_ready <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= ST_IDLE;
              end
            end
          end
          ST_WAIT_IDLE: begin
            if (w_clk_s && w_data_s) begin
              r_done  <= 1'b1;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
          default: begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign tx_ready    = r_ready;
  assign busy        = r_busy;
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign tx_done     = r_done;
  assign tx_err      = r_err;

endmodule
